// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch: classify GMII RX frames and forward them, delayed, to the ARP, ICMP or UDP receiver
module eth_rx_dispatch #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter int DELAY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_dv,
  output logic [7:0]  arp_rxd,
  output logic        icmp_rx_dv,
  output logic [7:0]  icmp_rxd,
  output logic        udp_rx_dv,
  output logic [7:0]  udp_rxd,
  output logic [15:0] drop_cnt
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RX} state_t;
  localparam logic [1:0] R_DROP = 2'd0, R_ARP = 2'd1, R_ICMP = 2'd2, R_UDP = 2'd3;

  state_t      state;
  logic [5:0]  cnt, idx;
  logic        pre_ok, mac_ok, bc_ok, sof, take, in_mac, pre_b;
  logic [47:0] mac_sh;
  logic [15:0] ether_type;
  logic [1:0]  pending_route, out_route, decision, route_now;
  logic [DELAY-1:0] dl_dv, dl_sof;
  logic [7:0]  dl_d [DELAY];

  assign sof = state == IDLE && gmii_rx_dv;
  assign take = sof || (state == RX && gmii_rx_dv);
  assign idx = sof ? 6'd0 : cnt;
  assign in_mac = idx >= 6'd8 && idx <= 6'd13;
  assign pre_b = idx <= 6'd6 ? gmii_rxd == 8'h55 : idx == 6'd7 ? gmii_rxd == 8'hD5 : 1'b1;
  // gmii_rxd is the IPv4 protocol byte when this is consumed (i=31)
  assign decision = !(pre_ok && (mac_ok || bc_ok)) ? R_DROP :
                    ether_type == 16'h0806 ? R_ARP :
                    ether_type != 16'h0800 ? R_DROP :
                    gmii_rxd == 8'd1 ? R_ICMP :
                    gmii_rxd == 8'd17 ? R_UDP : R_DROP;
  // a frame's route takes effect exactly when its first byte leaves the delay line
  assign route_now = dl_sof[DELAY-1] ? pending_route : out_route;

  // frame tracking, header checks and per-frame route decision
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_IDLE;
      cnt <= 6'd0;
      pre_ok <= 1'b0;
      mac_ok <= 1'b0;
      bc_ok <= 1'b0;
      mac_sh <= 48'd0;
      ether_type <= 16'd0;
      pending_route <= R_DROP;
    end else begin
      state <= !gmii_rx_dv ? IDLE : state == WAIT_IDLE ? WAIT_IDLE : RX;
      if (take) begin
        cnt <= idx == 6'd63 ? idx : idx + 6'd1;
        pre_ok <= (sof || pre_ok) && pre_b;
        mac_ok <= (sof || mac_ok) && (!in_mac || gmii_rxd == mac_sh[47:40]);
        bc_ok <= (sof || bc_ok) && (!in_mac || gmii_rxd == 8'hFF);
        mac_sh <= sof ? BOARD_MAC : in_mac ? mac_sh << 8 : mac_sh;
        ether_type <= idx == 6'd20 ? {gmii_rxd, ether_type[7:0]} :
                      idx == 6'd21 ? {ether_type[15:8], gmii_rxd} : ether_type;
        pending_route <= sof ? R_DROP : idx == 6'd31 ? decision : pending_route;
      end
    end
  end

  // delay line holding each byte until its frame's route is known
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_dv <= '0;
      dl_sof <= '0;
      for (int k = 0; k < DELAY; k++) dl_d[k] <= 8'h00;
    end else begin
      dl_dv <= {dl_dv[DELAY-2:0], take};
      dl_sof <= {dl_sof[DELAY-2:0], sof};
      dl_d[0] <= take ? gmii_rxd : 8'h00;
      for (int k = 1; k < DELAY; k++) dl_d[k] <= dl_d[k-1];
    end
  end

  // registered per-port outputs and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_route <= R_DROP;
      arp_rx_dv <= 1'b0;
      arp_rxd <= 8'h00;
      icmp_rx_dv <= 1'b0;
      icmp_rxd <= 8'h00;
      udp_rx_dv <= 1'b0;
      udp_rxd <= 8'h00;
      drop_cnt <= 16'd0;
    end else begin
      out_route <= route_now;
      arp_rx_dv <= dl_dv[DELAY-1] && route_now == R_ARP;
      arp_rxd <= route_now == R_ARP ? dl_d[DELAY-1] : 8'h00;
      icmp_rx_dv <= dl_dv[DELAY-1] && route_now == R_ICMP;
      icmp_rxd <= route_now == R_ICMP ? dl_d[DELAY-1] : 8'h00;
      udp_rx_dv <= dl_dv[DELAY-1] && route_now == R_UDP;
      udp_rxd <= route_now == R_UDP ? dl_d[DELAY-1] : 8'h00;
      drop_cnt <= dl_sof[DELAY-1] && route_now == R_DROP && drop_cnt != 16'hFFFF ? drop_cnt + 16'd1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_eth_rx_dispatch.sv
// tb_eth_rx_dispatch: directed frames checked against a frame-level model every cycle
module tb_eth_rx_dispatch;
  localparam int D = 32;
  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam int N = 4096;

  logic clk = 1'b0, reset = 1'b1, dv = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic arp_rx_dv, icmp_rx_dv, udp_rx_dv;
  logic [7:0] arp_rxd, icmp_rxd, udp_rxd;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  eth_rx_dispatch #(.BOARD_MAC(MAC), .DELAY(D)) dut (
    .clk(clk), .reset(reset), .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .arp_rx_dv(arp_rx_dv), .arp_rxd(arp_rxd),
    .icmp_rx_dv(icmp_rx_dv), .icmp_rxd(icmp_rxd),
    .udp_rx_dv(udp_rx_dv), .udp_rxd(udp_rxd),
    .drop_cnt(drop_cnt)
  );

  // model state (written only by the model process)
  int cyc = 0, last_rst = 0, fs = 0, m_route = 0, seen_gen = 0;
  bit h_acc [N];
  bit h_sof [N];
  logic [7:0] h_d [N];
  int route_of [N];
  bit armed = 1'b0, infr = 1'b0;
  logic [7:0] fb [$];
  logic [15:0] m_cnt = 16'd0;
  logic [42:0] exp_v = '0;

  // stimulus/check state (written only by the stimulus process)
  int gen = 0, n_cmp = 0, n_bad = 0;
  bit o_dv [3][N];
  logic [7:0] fr [$];

  // route of a frame from its first 32 bytes: 0 drop, 1 arp, 2 icmp, 3 udp
  function automatic int classify();
    bit ok = 1'b1;
    logic [47:0] dst;
    logic [15:0] et;
    for (int i = 0; i < 7; i++) if (fb[i] != 8'h55) ok = 1'b0;
    if (fb[7] != 8'hD5) ok = 1'b0;
    dst = {fb[8], fb[9], fb[10], fb[11], fb[12], fb[13]};
    if (dst != MAC && dst != 48'hFFFF_FFFF_FFFF) ok = 1'b0;
    et = {fb[20], fb[21]};
    if (!ok) return 0;
    if (et == 16'h0806) return 1;
    if (et == 16'h0800 && fb[31] == 8'd1) return 2;
    if (et == 16'h0800 && fb[31] == 8'd17) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int s;
    logic edv;
    logic [7:0] ed;
    cyc = cyc + 1;
    if (cyc >= N) begin
      $display("FAIL cycle_budget exceeded at %0d (limit %0d)", cyc, N);
      $fatal(1);
    end
    if (gen != seen_gen) begin
      seen_gen = gen;
      m_cnt = 16'hFFFE;
    end
    h_acc[cyc] = 1'b0;
    h_sof[cyc] = 1'b0;
    h_d[cyc] = rxd;
    if (reset) begin
      armed = 1'b0;
      infr = 1'b0;
      last_rst = cyc;
    end else if (!dv) begin
      infr = 1'b0;
      armed = 1'b1;
    end else if (infr) begin
      h_acc[cyc] = 1'b1;
      fb.push_back(rxd);
      if (fb.size() == 32) route_of[fs] = classify();
    end else if (armed) begin
      infr = 1'b1;
      fs = cyc;
      fb.delete();
      fb.push_back(rxd);
      h_acc[cyc] = 1'b1;
      h_sof[cyc] = 1'b1;
      route_of[cyc] = 0;
    end
    s = cyc - D;
    if (reset) begin
      m_route = 0;
      m_cnt = 16'd0;
      exp_v = '0;
    end else begin
      edv = 1'b0;
      ed = 8'h00;
      if (s > last_rst) begin
        if (h_sof[s]) begin
          m_route = route_of[s];
          if (m_route == 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        edv = h_acc[s];
        ed = edv ? h_d[s] : 8'h00;
      end
      exp_v = {m_route == 1 && edv, m_route == 1 ? ed : 8'h00,
               m_route == 2 && edv, m_route == 2 ? ed : 8'h00,
               m_route == 3 && edv, m_route == 3 ? ed : 8'h00, m_cnt};
    end
  end

  task automatic step();
    logic [42:0] got;
    @(posedge clk);
    #1;
    got = {arp_rx_dv, arp_rxd, icmp_rx_dv, icmp_rxd, udp_rx_dv, udp_rxd, drop_cnt};
    o_dv[0][cyc] = arp_rx_dv;
    o_dv[1][cyc] = icmp_rx_dv;
    o_dv[2][cyc] = udp_rx_dv;
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL outputs cycle %0d got %h expected %h", cyc, got, exp_v);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int count(input int p, input int a, input int b);
    int n = 0;
    for (int c = a; c < b; c++) n += int'(o_dv[p][c]);
    return n;
  endfunction

  function automatic int first_dv(input int p, input int a, input int b);
    for (int c = a; c < b; c++) if (o_dv[p][c]) return c;
    return -1;
  endfunction

  task automatic make(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] proto,
                      input int len, input logic [7:0] sfd);
    logic [7:0] b;
    fr.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 7) b = 8'h55;
      else if (i == 7) b = sfd;
      else if (i < 14) b = dst[8*(13-i) +: 8];
      else if (i < 20) b = 8'(8'hA0 + i);
      else if (i == 20) b = et[15:8];
      else if (i == 21) b = et[7:0];
      else if (i == 31) b = proto;
      else b = 8'(i * 7 + 3);
      fr.push_back(b);
    end
  endtask

  task automatic send(input int gap, input int rst_at);
    foreach (fr[i]) begin
      reset = (i == rst_at);
      dv = 1'b1;
      rxd = fr[i];
      step();
    end
    reset = 1'b0;
    dv = 1'b0;
    rxd = 8'h00;
    repeat (gap) step();
  endtask

  initial begin
    int a, t0, last_u, first_a;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_drop_cnt", int'(drop_cnt), 0);
    chk("reset_dv", int'({arp_rx_dv, icmp_rx_dv, udp_rx_dv}), 0);

    make(48'hFFFF_FFFF_FFFF, 16'h0806, 8'h00, 64, 8'hD5);
    a = cyc;
    t0 = cyc;
    send(40, -1);
    chk("arp_latency", first_dv(0, a, cyc + 1) - t0, 33);
    chk("arp_len", count(0, a, cyc + 1), 64);
    chk("arp_other", count(1, a, cyc + 1) + count(2, a, cyc + 1), 0);

    make(MAC, 16'h0800, 8'd1, 98, 8'hD5);
    a = cyc;
    send(40, -1);
    chk("icmp_len", count(1, a, cyc + 1), 98);
    chk("icmp_other", count(0, a, cyc + 1) + count(2, a, cyc + 1), 0);
    make(MAC, 16'h0800, 8'd17, 98, 8'hD5);
    a = cyc;
    send(40, -1);
    chk("udp_len", count(2, a, cyc + 1), 98);
    chk("udp_other", count(0, a, cyc + 1) + count(1, a, cyc + 1), 0);
    chk("no_drops", int'(drop_cnt), 0);

    a = cyc;
    make(MAC ^ 48'h1, 16'h0800, 8'd17, 64, 8'hD5);
    send(40, -1);
    make(MAC, 16'h0800, 8'd17, 64, 8'hD4);
    send(40, -1);
    make(48'hFFFF_FFFF_FFFF, 16'h86DD, 8'd17, 64, 8'hD5);
    send(40, -1);
    make(MAC, 16'h0800, 8'd17, 20, 8'hD5);
    send(40, -1);
    chk("drop_dv", count(0, a, cyc + 1) + count(1, a, cyc + 1) + count(2, a, cyc + 1), 0);
    chk("drop_cnt4", int'(drop_cnt), 4);

    a = cyc;
    make(MAC, 16'h0800, 8'd17, 200, 8'hD5);
    send(1, -1);
    make(48'hFFFF_FFFF_FFFF, 16'h0806, 8'h00, 64, 8'hD5);
    send(40, -1);
    last_u = -1;
    for (int c = a; c <= cyc; c++) if (o_dv[2][c]) last_u = c;
    first_a = first_dv(0, a, cyc + 1);
    chk("b2b_gap", first_a - last_u, 2);
    chk("b2b_udp", count(2, a, cyc + 1), 200);
    chk("b2b_arp", count(0, a, cyc + 1), 64);

    a = cyc;
    make(MAC, 16'h0800, 8'd17, 200, 8'hD5);
    send(2, 40);
    make(MAC, 16'h0800, 8'd1, 98, 8'hD5);
    send(40, -1);
    chk("rst_udp_partial", count(2, a, cyc + 1), 8);
    chk("rst_icmp_after", count(1, a, cyc + 1), 98);
    chk("rst_drop_cnt", int'(drop_cnt), 0);

    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    gen++;
    step();
    chk("preload", int'(drop_cnt), 16'hFFFE);
    make(MAC, 16'h0800, 8'd17, 20, 8'hD5);
    send(40, -1);
    chk("sat_first", int'(drop_cnt), 16'hFFFF);
    send(40, -1);
    send(40, -1);
    chk("sat_hold", int'(drop_cnt), 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
